// File: rtl/iz_link_pkg.sv
// Izhikevich parameter load link: shared constants, FSM states
// and the frame checksum used by both serializer and loader.
package iz_link_pkg;

  localparam int IZ_PARAM_W    = 16;
  localparam int IZ_NUM_PARAMS = 4;
  localparam int IZ_FRAME_W    = IZ_PARAM_W * IZ_NUM_PARAMS;
  localparam int IZ_CHK_W      = 8;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    CHK,
    GAP
  } iz_state_t;

  // XOR of all frame bytes
  function automatic logic [IZ_CHK_W-1:0] iz_chk_xor(
    input logic [IZ_FRAME_W-1:0] f
  );
    logic [IZ_CHK_W-1:0] acc;
    acc = '0;
    for (int i = 0; i < IZ_FRAME_W / IZ_CHK_W; i++)
      acc = acc ^ f[i*IZ_CHK_W +: IZ_CHK_W];
    return acc;
  endfunction

endpackage

// File: rtl/iz_bit_timer.sv
// Serial bit timer: counts 0..CLK_DIV-1, flags the last
// cycle of each bit; freezes with i_en low, zeroes on i_clr.
module iz_bit_timer #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_en,
  input  logic i_clr,
  output logic o_last,
  output logic o_tick
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] r_cnt;

  // divider count, wraps at the end of every bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_cnt <= '0;
    else if (i_clr)
      r_cnt <= '0;
    else if (i_en)
      r_cnt <= o_last ? '0 : r_cnt + CW'(1);
  end

  assign o_last = (r_cnt == LAST);
  assign o_tick = i_en & o_last;

endmodule

// File: rtl/iz_param_serializer.sv
// Host-side serializer for the Izhikevich parameter load link.
// Define IZ_SER_CHECKSUM_EN to append an 8-bit XOR checksum.
module iz_param_serializer
  import iz_link_pkg::*;
#(
  parameter int CLK_DIV    = 4,
  parameter int PARAM_W    = IZ_PARAM_W,
  parameter int NUM_PARAMS = IZ_NUM_PARAMS
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic               start,
  output logic               ready,
  input  logic [PARAM_W-1:0] param_a,
  input  logic [PARAM_W-1:0] param_b,
  input  logic [PARAM_W-1:0] param_c,
  input  logic [PARAM_W-1:0] param_d,
  output logic               load_mode,
  output logic               serial_data,
  output logic               busy,
  output logic               done
);

  localparam int FRAME_W = NUM_PARAMS * PARAM_W;
  localparam int BCW =
    (FRAME_W > 1) ? $clog2(FRAME_W) : 1;
  localparam logic [BCW-1:0] LAST_BIT =
    BCW'(FRAME_W - 1);

  iz_state_t r_state;
  iz_state_t w_next;

  logic [FRAME_W-1:0] r_shreg;
  logic [BCW-1:0]     r_bit;
  logic               w_accept;
  logic               w_last;
  logic               w_tick;
  logic [FRAME_W-1:0] w_frame;

`ifdef IZ_SER_CHECKSUM_EN
  localparam logic [BCW-1:0] LAST_CHK =
    BCW'(IZ_CHK_W - 1);
  logic [IZ_CHK_W-1:0] r_chk;
`endif

  assign w_frame  = {param_a, param_b, param_c, param_d};
  assign w_accept = start & enable & (r_state == IDLE);

  iz_bit_timer #(
    .CLK_DIV (CLK_DIV)
  ) u_timer (
    .clk    (clk),
    .rst_n  (reset),
    .i_en   (enable),
    .i_clr  (r_state == IDLE),
    .o_last (w_last),
    .o_tick (w_tick)
  );

  // state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      r_state <= IDLE;
    else
      r_state <= w_next;
  end

  // next state and link outputs
  always_comb begin
    w_next      = r_state;
    ready       = 1'b0;
    load_mode   = 1'b0;
    serial_data = 1'b0;
    done        = 1'b0;
    unique case (r_state)
      IDLE: begin
        ready = 1'b1;
        if (w_accept)
          w_next = SHIFT;
      end
      SHIFT: begin
        load_mode   = 1'b1;
        serial_data = r_shreg[FRAME_W-1];
        if (w_tick && r_bit == LAST_BIT)
`ifdef IZ_SER_CHECKSUM_EN
          w_next = CHK;
`else
          w_next = GAP;
`endif
      end
      CHK: begin
`ifdef IZ_SER_CHECKSUM_EN
        load_mode   = 1'b1;
        serial_data = r_chk[IZ_CHK_W-1];
        if (w_tick && r_bit == LAST_CHK)
          w_next = GAP;
`else
        w_next = IDLE;
`endif
      end
      GAP: begin
        done = w_last;
        if (w_tick)
          w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
    busy = ~ready;
  end

  // frame shift register and bit counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_shreg <= '0;
      r_bit   <= '0;
    end else if (w_accept) begin
      r_shreg <= w_frame;
      r_bit   <= '0;
    end else if (w_tick) begin
      if (r_state == SHIFT) begin
        r_shreg <= {r_shreg[FRAME_W-2:0], 1'b0};
        r_bit   <= (r_bit == LAST_BIT) ?
                   '0 : r_bit + BCW'(1);
      end
`ifdef IZ_SER_CHECKSUM_EN
      else if (r_state == CHK) begin
        r_bit <= (r_bit == LAST_CHK) ?
                 '0 : r_bit + BCW'(1);
      end
`endif
    end
  end

`ifdef IZ_SER_CHECKSUM_EN
  // checksum captured with the frame, shifted out after it
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      r_chk <= '0;
    else if (w_accept)
      r_chk <= iz_chk_xor(w_frame);
    else if (w_tick && r_state == CHK)
      r_chk <= {r_chk[IZ_CHK_W-2:0], 1'b0};
  end
`endif

endmodule
